// File: rtl/spi_master.sv
// 16-bit mode-0 SPI initiator (CPOL=0, CPHA=0, MSB first) with registered outputs.
// Optional back-to-back words under one ss-low window: define SPI_BURST_EN.
`timescale 1ns/1ps
module spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 4,
    parameter int SS_HOLD  = 2,
    parameter int SS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_data,
    output logic        ss,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
`ifdef SPI_BURST_EN
    ,
    input  logic        burst
`endif
);

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(SS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(SS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
`ifdef SPI_BURST_EN
        ,
        S_WAIT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] rx_q, rx_d;
    logic        ss_q, ss_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef SPI_BURST_EN
    // Set when a burst ends from WAIT: its done was already given at bit 15.
    logic        nodone_q, nodone_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
            ss_q     <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPI_BURST_EN
            nodone_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            ss_q     <= ss_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SPI_BURST_EN
            nodone_q <= nodone_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        ss_d     = ss_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SPI_BURST_EN
        nodone_d = nodone_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d    = tx_data;
                    bit_d   = '0;
                    cnt_d   = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = tx_data[15];
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOW: begin
                // miso is captured on the same edge that raises sck.
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    sh_d    = {sh_q[14:0], miso};
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = '0;
                    sck_d  = 1'b0;
                    mosi_d = sh_q[15];
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
`ifdef SPI_BURST_EN
                        if (burst) begin
                            rx_d    = sh_q;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_HOLD;
                        end
`else
                        state_d = S_HOLD;
`endif
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    state_d = S_GAP;
`ifdef SPI_BURST_EN
                    if (!nodone_q) begin
                        rx_d   = sh_q;
                        done_d = 1'b1;
                    end
`else
                    rx_d   = sh_q;
                    done_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
`ifdef SPI_BURST_EN
                    nodone_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef SPI_BURST_EN
            S_WAIT: begin
                // Start takes priority over ending the burst.
                if (start) begin
                    sh_d    = tx_data;
                    bit_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    mosi_d  = tx_data[15];
                    state_d = S_LOW;
                end else if (!burst) begin
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    nodone_d = 1'b1;
                    state_d  = S_HOLD;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign ss      = ss_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and slave-model transfers, ignored restarts,
// mid-transfer reset and, with SPI_BURST_EN, a two-word burst.
`timescale 1ns/1ps
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    wire         busy, done, ss, sck, mosi, miso;
    wire  [15:0] rx_data;
`ifdef SPI_BURST_EN
    logic        burst = 1'b0;
`endif

    logic        loop_mode = 1'b1;
    logic [15:0] s_din = 16'h0000;
    logic [15:0] s_sh = 16'h0000;
    logic [15:0] s_rx = 16'h0000;
    logic        s_ss_p = 1'b1;
    logic        s_sck_p = 1'b0;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    spi_master dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .ss      (ss),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso)
`ifdef SPI_BURST_EN
        ,
        .burst   (burst)
`endif
    );

    assign miso = loop_mode ? mosi : s_sh[15];

    // Oversampling mode-0 slave: loads din on ss fall, samples on sck rise, shifts on sck fall.
    always @(posedge clk) begin
        if (s_ss_p && !ss)
            s_sh <= s_din;
        else if (!ss && s_sck_p && !sck)
            s_sh <= {s_sh[14:0], 1'b0};
        if (!ss && !s_sck_p && sck)
            s_rx <= {s_rx[14:0], mosi};
        s_ss_p  <= ss;
        s_sck_p <= sck;
    end

    always @(posedge sck) rise_cnt <= rise_cnt + 1;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full non-burst transfer; optionally re-pulses start at cycles 10 and 60.
    task automatic xfer(input string tag, input logic [15:0] tx, input logic [15:0] exp_rx,
                        input bit dbl);
        int n, r0, d0;
        r0 = rise_cnt;
        d0 = done_cnt;
        tx_data = tx;
        start = 1'b1;
        tick();
        n = 1;
        start = 1'b0;
        tx_data = ~tx;
        check({tag, ".busy_up"}, busy, 1);
        check({tag, ".ss_low"}, ss, 0);
        check({tag, ".mosi_msb"}, mosi, tx[15]);
        while (!done && n < 400) begin
            start = dbl && (n == 10 || n == 60);
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, ".done_lat"}, n, 135);
        check({tag, ".rx"}, rx_data, exp_rx);
        check({tag, ".ss_high"}, ss, 1);
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({tag, ".busy_lat"}, n, 139);
        check({tag, ".rises"}, rise_cnt - r0, 16);
        check({tag, ".dones"}, done_cnt - d0, 1);
        $display("xfer %s tx=%h rx=%h cycles=%0d", tag, tx, rx_data, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, n;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst.ss", ss, 1);
        check("rst.sck", sck, 0);
        check("rst.mosi", mosi, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.rx", rx_data, 16'h0000);
        $display("reset released: ss=%b sck=%b busy=%b rx=%h", ss, sck, busy, rx_data);

        loop_mode = 1'b1;
        xfer("loop_a5c3", 16'hA5C3, 16'hA5C3, 1'b0);

        loop_mode = 1'b0;
        s_din = 16'h1234;
        xfer("slave1", 16'hBEEF, 16'h1234, 1'b0);
        check("slave1.dout", s_rx, 16'hBEEF);
        s_din = 16'hC00F;
        xfer("slave2", 16'h5A5A, 16'hC00F, 1'b0);
        check("slave2.dout", s_rx, 16'h5A5A);

        loop_mode = 1'b1;
        xfer("restart_ign", 16'h3C96, 16'h3C96, 1'b1);

        r0 = rise_cnt;
        d0 = done_cnt;
        tx_data = 16'h1357;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (rise_cnt - r0 < 7 && n < 400) begin
            tick();
            n++;
        end
        check("abort.rises", rise_cnt - r0, 7);
        rst_n = 1'b0;
        #1;
        check("abort.ss", ss, 1);
        check("abort.sck", sck, 0);
        check("abort.busy", busy, 0);
        check("abort.rx", rx_data, 16'h0000);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("abort.dones", done_cnt - d0, 0);
        $display("xfer abort tx=1357 reset after %0d rises", rise_cnt - r0);
        xfer("post_rst", 16'h0001, 16'h0001, 1'b0);

`ifdef SPI_BURST_EN
        r0 = rise_cnt;
        d0 = done_cnt;
        burst = 1'b1;
        tx_data = 16'h00FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("burst1.lat", n, 133);
        check("burst1.rx", rx_data, 16'h00FF);
        check("burst1.ss", ss, 0);
        check("burst1.busy", busy, 0);
        $display("xfer burst1 tx=00ff rx=%h cycles=%0d", rx_data, n);
        tx_data = 16'hFF00;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("burst2.rx", rx_data, 16'hFF00);
        check("burst2.ss", ss, 0);
        burst = 1'b0;
        n = 0;
        while (!ss && n < 100) begin
            tick();
            n++;
        end
        while (busy && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("burst.ss_end", ss, 1);
        check("burst.rises", rise_cnt - r0, 32);
        check("burst.dones", done_cnt - d0, 2);
        $display("xfer burst2 tx=ff00 rx=%h rises=%0d", rx_data, rise_cnt - r0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
